// File: rtl/paralelo_serial_pkg.sv
// Symbols and state encoding shared by both ends of the serial link.
// The receive side uses the same constants for alignment.
package pcie_simbolos;

  localparam int         SYM_WIDTH = 8;
  localparam logic [7:0] SIM_COM   = 8'hBC;

  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;

  // The state is chosen only at a load edge, by whether a byte was waiting.
  function automatic logic [1:0] estado_carga(input logic lleno);
    return lleno ? S_DATA : S_IDLE;
  endfunction

endpackage

// File: rtl/paralelo_serial_contador_bits.sv
// Bit position counter for one symbol: counts enabled cycles modulo WIDTH.
// carga flags position 0, where the next symbol is loaded.
module contador_bits #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enb,
  output logic [CW-1:0] bit_cnt,
  output logic          carga
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_cnt <= '0;
    end else if (enb) begin
      if (bit_cnt == CW'(WIDTH - 1)) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

  assign carga = (bit_cnt == '0);

endmodule

// File: rtl/paralelo_serial.sv
// Serial link transmitter: one-deep holding register feeding an MSB-first shift
// register, with the COM symbol filling every slot that has no byte pending.
module paralelo_serial
  import pcie_simbolos::*;
#(
  parameter int               WIDTH    = SYM_WIDTH,
  parameter logic [WIDTH-1:0] IDLE_SYM = SIM_COM
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic [WIDTH-1:0] entradas,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             salida,
  output logic             inicio,
  output logic             es_dato,
  output logic [1:0]       estado
);

  localparam int CW = $clog2(WIDTH);

  // Handshake: a byte moves into hold on a posedge where valid_in and
  // ready_out are both high; upstream keeps entradas stable until then.
  logic [CW-1:0]    bit_cnt;
  logic             carga;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [WIDTH-1:0] src;
  logic             acepta;

  contador_bits #(.WIDTH(WIDTH), .CW(CW)) u_contador (
    .clk     (clk),
    .reset   (reset),
    .enb     (enb),
    .bit_cnt (bit_cnt),
    .carga   (carga)
  );

  assign ready_out = ~hold_full & enb;
  assign acepta    = valid_in & ready_out;
  assign src       = hold_full ? hold : IDLE_SYM;

  always_ff @(posedge clk) begin
    if (!reset) begin
      salida    <= 1'b0;
      inicio    <= 1'b0;
      es_dato   <= 1'b0;
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      estado    <= S_RESET;
    end else if (enb) begin
      if (carga) begin
        salida    <= src[WIDTH-1];
        shift     <= src << 1;
        inicio    <= 1'b1;
        es_dato   <= hold_full;
        hold_full <= 1'b0;
        estado    <= estado_carga(hold_full);
      end else begin
        salida <= shift[WIDTH-1];
        shift  <= shift << 1;
        inicio <= 1'b0;
      end
      // An accept on a load edge with hold empty waits for the next load.
      if (acepta) begin
        hold      <= entradas;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_paralelo_serial.sv
// Bench for paralelo_serial: a symbol-level model (pending-byte queue plus bit
// position within the symbol) predicts every output on every cycle.
module tb_paralelo_serial;
  import pcie_simbolos::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enb = 1'b0;
  logic         valid_in = 1'b0;
  logic [W-1:0] entradas = '0;
  logic         ready_out, salida, inicio, es_dato;
  logic [1:0]   estado;

  paralelo_serial dut (
    .clk(clk), .reset(reset), .enb(enb), .entradas(entradas),
    .valid_in(valid_in), .ready_out(ready_out), .salida(salida),
    .inicio(inicio), .es_dato(es_dato), .estado(estado)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [W-1:0] pend_q[$];
  logic [W-1:0] m_sym = '0;
  int           m_pos = 0;
  logic         m_salida = 1'b0, m_inicio = 1'b0, m_dato = 1'b0;
  logic [1:0]   m_estado = S_RESET;
  logic         last_en = 1'b0;
  logic         last_acc = 1'b0;
  logic [W-1:0] exp_q[$];

  function automatic logic [5:0] exp_vec();
    return {m_salida, m_inicio, m_dato, (enb && pend_q.size() == 0), m_estado};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {salida, inicio, es_dato, ready_out, estado};
  endfunction

  // One clock: inputs are already driven; the model advances on the same edge.
  task automatic tick();
    logic acc;
    acc = valid_in && enb && reset && (pend_q.size() == 0);
    @(posedge clk);
    last_en  = reset && enb;
    last_acc = acc;
    if (!reset) begin
      pend_q.delete();
      m_pos = 0; m_salida = 1'b0; m_inicio = 1'b0; m_dato = 1'b0;
      m_estado = S_RESET; m_sym = '0;
    end else if (enb) begin
      if (m_pos == 0) begin
        if (pend_q.size() > 0) begin
          m_sym = pend_q.pop_front(); m_dato = 1'b1; m_estado = S_DATA;
        end else begin
          m_sym = SIM_COM; m_dato = 1'b0; m_estado = S_IDLE;
        end
      end
      m_salida = m_sym[W-1-m_pos];
      m_inicio = (m_pos == 0);
      m_pos    = (m_pos + 1) % W;
      if (acc) pend_q.push_back(entradas);
    end
    #1;
  endtask

  task automatic test_reset();
    logic [W-1:0] pat;
    pat = 8'hBC;
    reset = 1'b0; enb = 1'b1; valid_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (dut_vec() !== {3'b000, 1'b1, S_RESET}) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, dut_vec(), {3'b000, 1'b1, S_RESET});
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (salida !== pat[W-1-(i%W)] || inicio !== (i%W == 0) || es_dato !== 1'b0 ||
          dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL idle_pattern cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single_byte();
    logic [W-1:0] got;
    int nbits;
    got = '0; nbits = 0;
    while (m_pos != 3) tick();
    valid_in = 1'b1; entradas = 8'h66;
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single_cycle cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
      if (es_dato) begin got = {got[W-2:0], salida}; nbits++; end
    end
    checks++;
    if (got !== 8'h66 || nbits != 8) begin
      errors++;
      $display("FAIL single_byte got=%h bits=%0d exp=66 bits=8", got, nbits);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] b [4];
    logic [31:0]  stream;
    int idx, n, budget;
    logic gap;
    b[0] = 8'h66; b[1] = 8'hA5; b[2] = 8'h80; b[3] = 8'h7F;
    idx = 0; n = 0; budget = 0; gap = 1'b0; stream = '0;
    while (n < 32 && budget < 100) begin
      valid_in = (idx < 4);
      entradas = b[idx < 4 ? idx : 3];
      tick();
      budget++;
      if (last_acc) idx++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_cycle cyc=%0d got=%b exp=%b", budget, dut_vec(), exp_vec());
      end
      if (es_dato) begin
        checks++;
        if (inicio !== (n % 8 == 0)) begin
          errors++;
          $display("FAIL b2b_inicio bit=%0d got=%b exp=%b", n, inicio, (n % 8 == 0));
        end
        stream = {stream[30:0], salida};
        n++;
      end else if (n > 0) begin
        gap = 1'b1;
      end
    end
    valid_in = 1'b0;
    checks++;
    if (stream !== 32'h66A5807F || gap || n != 32) begin
      errors++;
      $display("FAIL b2b_stream got=%h gap=%b bits=%0d exp=66a5807f gap=0 bits=32", stream, gap, n);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] got;
    int nbits, budget;
    got = '0; nbits = 0; budget = 0;
    while (m_pos != 2 || pend_q.size() != 0) tick();
    valid_in = 1'b1; entradas = 8'h3C;
    tick();
    while (nbits < 8 && budget < 40) begin
      valid_in = (pend_q.size() > 0);
      entradas = W'($urandom_range(0, 255));
      #1;
      if (valid_in) begin
        checks++;
        if (ready_out !== 1'b0) begin
          errors++;
          $display("FAIL bp_ready got=%b exp=0", ready_out);
        end
      end
      tick();
      budget++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL bp_cycle cyc=%0d got=%b exp=%b", budget, dut_vec(), exp_vec());
      end
      if (es_dato) begin got = {got[W-2:0], salida}; nbits++; end
    end
    valid_in = 1'b0;
    checks++;
    if (got !== 8'h3C) begin
      errors++;
      $display("FAIL bp_byte got=%h exp=3c", got);
    end
  endtask

  task automatic test_enable();
    logic [W-1:0] got;
    logic [5:0]   frozen;
    int nbits, budget;
    got = '0; nbits = 0; budget = 0;
    while (pend_q.size() != 0 || m_pos != 5) tick();
    valid_in = 1'b1; entradas = 8'hA5;
    tick();
    valid_in = 1'b0;
    while (nbits < 8 && budget < 40) begin
      if (m_dato && m_pos == 4 && enb) begin
        frozen = dut_vec();
        enb = 1'b0;
        for (int i = 0; i < 5; i++) begin
          tick();
          checks++;
          if (dut_vec() !== exp_vec() || {salida, inicio} !== frozen[5:4] || ready_out !== 1'b0) begin
            errors++;
            $display("FAIL enb_freeze cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
          end
        end
        enb = 1'b1;
      end
      tick();
      budget++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL enb_cycle cyc=%0d got=%b exp=%b", budget, dut_vec(), exp_vec());
      end
      if (es_dato) begin got = {got[W-2:0], salida}; nbits++; end
    end
    checks++;
    if (got !== 8'hA5) begin
      errors++;
      $display("FAIL enb_byte got=%h exp=a5", got);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] pat;
    int nbits, budget;
    pat = 8'hBC; nbits = 0; budget = 0;
    while (pend_q.size() != 0) tick();
    valid_in = 1'b1; entradas = 8'hA5;
    tick();
    while (nbits < 3 && budget < 40) begin
      valid_in = m_dato;
      entradas = 8'h80;
      tick();
      budget++;
      if (es_dato) nbits++;
    end
    valid_in = 1'b0;
    checks++;
    if (pend_q.size() != 1) begin
      errors++;
      $display("FAIL rst_mid_setup got=%0d exp=1 bytes in hold", pend_q.size());
    end
    reset = 1'b0;
    tick();
    checks++;
    if (dut_vec() !== {3'b000, 1'b1, S_RESET}) begin
      errors++;
      $display("FAIL rst_mid_reset got=%b exp=%b", dut_vec(), {3'b000, 1'b1, S_RESET});
    end
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (salida !== pat[W-1-(i%W)] || es_dato !== 1'b0 || dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rst_mid_idle cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] acc_byte, expb;
    int nbits;
    acc_byte = '0; nbits = 0;
    reset = 1'b0; tick(); reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 600; i++) begin
      enb = ($urandom_range(0, 9) < 8);
      if (!valid_in || last_acc) begin
        valid_in = $urandom_range(0, 1);
        entradas = W'($urandom_range(0, 255));
      end
      tick();
      if (last_acc) exp_q.push_back(entradas);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rand_cycle cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
      if (last_en && es_dato) begin
        if (inicio) nbits = 0;
        acc_byte = {acc_byte[W-2:0], salida};
        nbits++;
        if (nbits == W) begin
          expb = (exp_q.size() > 0) ? exp_q.pop_front() : ~acc_byte;
          checks++;
          if (acc_byte !== expb) begin
            errors++;
            $display("FAIL rand_byte got=%h exp=%h", acc_byte, expb);
          end
        end
      end
    end
    valid_in = 1'b0; enb = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_backpressure();
    test_enable();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
